// File: rtl/classify_accum_bank.sv
// Per-centroid lane accumulators and point counters with a handshaked drain readout.
// Define CLASSIFY_ACCUM_SAT_EN to clamp acc/cnt (and flag overflow) instead of wrapping.
module classify_accum_bank #(
    parameter int CENTROID_NUM = 8,
    parameter int DIM          = 7,
    parameter int COORD_WIDTH  = 13,
    parameter int ACCUM_WIDTH  = 22,
    parameter int COUNT_WIDTH  = 10,
    parameter int INDEX_WIDTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [INDEX_WIDTH-1:0]         in_index,
    input  logic [DIM*COORD_WIDTH-1:0]     in_point,
    input  logic                           clear,
    input  logic                           drain_start,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [INDEX_WIDTH-1:0]         out_id,
    output logic [DIM*ACCUM_WIDTH-1:0]     out_accum,
    output logic [COUNT_WIDTH-1:0]         out_count,
    output logic                           out_last,
    output logic                           drain_done,
    output logic                           err_index,
    output logic                           overflow
);
    // DONE is the post-drain cycle that carries drain_done before returning to ACCUM.
    typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;

    localparam logic [INDEX_WIDTH-1:0] LAST_ID = INDEX_WIDTH'(CENTROID_NUM - 1);
    localparam logic [INDEX_WIDTH:0]   K_LIM   = (INDEX_WIDTH + 1)'(CENTROID_NUM);

    state_t                 state_q, state_d;
    logic [ACCUM_WIDTH-1:0] acc_q [CENTROID_NUM][DIM];
    logic [ACCUM_WIDTH-1:0] acc_d [CENTROID_NUM][DIM];
    logic [COUNT_WIDTH-1:0] cnt_q [CENTROID_NUM];
    logic [COUNT_WIDTH-1:0] cnt_d [CENTROID_NUM];
    logic [INDEX_WIDTH-1:0] id_q, id_d;
    logic                   err_q, err_d;
    logic                   accept, idx_ok;

`ifdef CLASSIFY_ACCUM_SAT_EN
    logic                   ovf_q, ovf_d;
    logic [ACCUM_WIDTH:0]   lsum;
    logic [COUNT_WIDTH:0]   csum;
    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    assign in_ready   = (state_q == ACCUM);
    assign out_valid  = (state_q == DRAIN);
    assign drain_done = (state_q == DONE);
    assign out_id     = id_q;
    assign out_last   = out_valid && (id_q == LAST_ID);
    assign err_index  = err_q;
    assign accept     = in_valid && in_ready;
    assign idx_ok     = {1'b0, in_index} < K_LIM;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        err_d   = err_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
`ifdef CLASSIFY_ACCUM_SAT_EN
        ovf_d   = ovf_q;
        lsum    = '0;
        csum    = '0;
`endif
        if (accept && !idx_ok) err_d = 1'b1;

        for (int k = 0; k < CENTROID_NUM; k++) begin
            if (accept && idx_ok && in_index == INDEX_WIDTH'(k)) begin
                for (int l = 0; l < DIM; l++) begin
`ifdef CLASSIFY_ACCUM_SAT_EN
                    lsum = {1'b0, acc_q[k][l]} +
                           (ACCUM_WIDTH + 1)'(in_point[l*COORD_WIDTH +: COORD_WIDTH]);
                    if (lsum[ACCUM_WIDTH]) begin
                        acc_d[k][l] = '1;
                        ovf_d       = 1'b1;
                    end else begin
                        acc_d[k][l] = lsum[ACCUM_WIDTH-1:0];
                    end
`else
                    acc_d[k][l] = acc_q[k][l] +
                                  ACCUM_WIDTH'(in_point[l*COORD_WIDTH +: COORD_WIDTH]);
`endif
                end
`ifdef CLASSIFY_ACCUM_SAT_EN
                csum = {1'b0, cnt_q[k]} + 1'b1;
                if (csum[COUNT_WIDTH]) begin
                    cnt_d[k] = '1;
                    ovf_d    = 1'b1;
                end else begin
                    cnt_d[k] = csum[COUNT_WIDTH-1:0];
                end
`else
                cnt_d[k] = cnt_q[k] + 1'b1;
`endif
            end
        end

        // A point accepted alongside drain_start lands in acc_d before the first beat reads it.
        case (state_q)
            ACCUM: if (drain_start) begin
                state_d = DRAIN;
                id_d    = '0;
            end
            DRAIN: if (out_ready) begin
                if (id_q == LAST_ID) begin
                    state_d = DONE;
                    id_d    = '0;
                end else begin
                    id_d = id_q + 1'b1;
                end
            end
            DONE:    state_d = ACCUM;
            default: state_d = ACCUM;
        endcase

        if (clear) begin
            state_d = ACCUM;
            id_d    = '0;
            err_d   = 1'b0;
`ifdef CLASSIFY_ACCUM_SAT_EN
            ovf_d   = 1'b0;
`endif
            for (int k = 0; k < CENTROID_NUM; k++) begin
                cnt_d[k] = '0;
                for (int l = 0; l < DIM; l++) acc_d[k][l] = '0;
            end
        end
    end

    always_comb begin
        out_accum = '0;
        out_count = '0;
        for (int k = 0; k < CENTROID_NUM; k++) begin
            if (out_valid && id_q == INDEX_WIDTH'(k)) begin
                for (int l = 0; l < DIM; l++) out_accum[l*ACCUM_WIDTH +: ACCUM_WIDTH] = acc_q[k][l];
                out_count = cnt_q[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            id_q    <= '0;
            err_q   <= 1'b0;
`ifdef CLASSIFY_ACCUM_SAT_EN
            ovf_q   <= 1'b0;
`endif
            for (int k = 0; k < CENTROID_NUM; k++) begin
                cnt_q[k] <= '0;
                for (int l = 0; l < DIM; l++) acc_q[k][l] <= '0;
            end
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            err_q   <= err_d;
`ifdef CLASSIFY_ACCUM_SAT_EN
            ovf_q   <= ovf_d;
`endif
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_classify_accum_bank.sv
// Bench for classify_accum_bank: vector table, directed drain sequences, random traffic vs. a sum/count model.
module tb_classify_accum_bank;
    localparam int K  = 8;
    localparam int D  = 7;
    localparam int CW = 13;
    localparam int AW = 22;
    localparam int NW = 10;
    localparam int IW = 4;
    localparam longint AMAX = (64'd1 << AW) - 1;
    localparam longint NMAX = (64'd1 << NW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [IW-1:0]   in_index = '0;
    logic [D*CW-1:0] in_point = '0;
    logic            clear = 1'b0;
    logic            drain_start = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [IW-1:0]   out_id;
    logic [D*AW-1:0] out_accum;
    logic [NW-1:0]   out_count;
    logic            out_last;
    logic            drain_done;
    logic            err_index;
    logic            overflow;

    classify_accum_bank #(.CENTROID_NUM(K), .DIM(D), .COORD_WIDTH(CW), .ACCUM_WIDTH(AW),
                          .COUNT_WIDTH(NW), .INDEX_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_index(in_index),
        .in_point(in_point), .clear(clear), .drain_start(drain_start), .out_valid(out_valid),
        .out_ready(out_ready), .out_id(out_id), .out_accum(out_accum), .out_count(out_count),
        .out_last(out_last), .drain_done(drain_done), .err_index(err_index), .overflow(overflow));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain per-centroid lane sums and counts.
    longint m_acc [K][D];
    longint m_cnt [K];
    bit     m_err;
    bit     m_ovf;
    logic [D*AW-1:0] obs_acc [K];
    logic [NW-1:0]   obs_cnt [K];

`ifdef CLASSIFY_ACCUM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [D*CW-1:0] rep_pt(input int v);
        logic [D*CW-1:0] r;
        for (int l = 0; l < D; l++) r[l*CW +: CW] = CW'(v);
        return r;
    endfunction

    function automatic logic [D*AW-1:0] rep_acc(input int v);
        logic [D*AW-1:0] r;
        for (int l = 0; l < D; l++) r[l*AW +: AW] = AW'(v);
        return r;
    endfunction

    function automatic logic [D*AW-1:0] exp_acc(input int k);
        logic [D*AW-1:0] r;
        logic [63:0] t;
        for (int l = 0; l < D; l++) begin
            t = m_acc[k][l];
            r[l*AW +: AW] = t[AW-1:0];
        end
        return r;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < K; k++) begin
            m_cnt[k] = 0;
            for (int l = 0; l < D; l++) m_acc[k][l] = 0;
        end
        m_err = 0;
        m_ovf = 0;
    endtask

    task automatic model_accept(input int idx, input logic [D*CW-1:0] pt);
        longint s;
        if (idx >= K) begin
            m_err = 1;
            return;
        end
        for (int l = 0; l < D; l++) begin
            s = m_acc[idx][l] + longint'(pt[l*CW +: CW]);
            if (SAT && s > AMAX) begin s = AMAX; m_ovf = 1; end
            m_acc[idx][l] = s % (AMAX + 1);
        end
        s = m_cnt[idx] + 1;
        if (SAT && s > NMAX) begin s = NMAX; m_ovf = 1; end
        m_cnt[idx] = s % (NMAX + 1);
    endtask

    // Drain all K beats, optionally with a point accepted alongside drain_start and a stall at one id.
    task automatic drain(input bit with_pt, input int pidx, input int pval,
                         input int stall_id, input int stall_n);
        int k, st, cyc;
        @(negedge clk);
        drain_start = 1'b1;
        out_ready   = 1'b1;
        if (with_pt) begin
            in_valid = 1'b1;
            in_index = IW'(pidx);
            in_point = rep_pt(pval);
            model_accept(pidx, rep_pt(pval));
        end
        @(negedge clk);
        drain_start = 1'b0;
        in_valid    = 1'b0;
        k = 0; st = stall_n; cyc = 1;
        while (k < K && cyc < 200) begin
            chk("beat_valid", out_valid, 1);
            chk("in_ready_drain", in_ready, 0);
            chk("beat_id", out_id, k);
            chk("beat_accum", out_accum, exp_acc(k));
            chk("beat_count", out_count, m_cnt[k]);
            chk("beat_last", out_last, k == K - 1);
            obs_acc[k] = out_accum;
            obs_cnt[k] = out_count;
            if (k == stall_id && st > 0) begin
                out_ready = 1'b0;
                st--;
            end else begin
                out_ready = 1'b1;
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("drain_latency", cyc, K + 1 + stall_n);
        chk("done_pulse", drain_done, 1);
        chk("done_valid", out_valid, 0);
        chk("done_in_ready", in_ready, 0);
        @(negedge clk);
        chk("done_drop", drain_done, 0);
        chk("ready_after", in_ready, 1);
    endtask

    typedef struct {
        bit clr;
        bit vld;
        int idx;
        int val;
        bit exp_err;
    } row_t;
    row_t rows[9];

    task automatic apply_row(input int i);
        @(negedge clk);
        clear    = rows[i].clr;
        in_valid = rows[i].vld;
        in_index = IW'(rows[i].idx);
        in_point = rep_pt(rows[i].val);
        if (rows[i].clr) model_clear();
        else if (rows[i].vld) model_accept(rows[i].idx, rep_pt(rows[i].val));
        @(posedge clk);
        #1;
        chk("row_err", err_index, rows[i].exp_err);
        chk("row_in_ready", in_ready, 1);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    initial begin
        logic [D*CW-1:0] pt;
        int idx;
        rows[0] = '{0, 1, 2, 5, 0};
        rows[1] = '{0, 1, 2, 5, 0};
        rows[2] = '{0, 1, 2, 5, 0};
        rows[3] = '{0, 1, 7, 100, 0};
        rows[4] = '{1, 0, 0, 0, 0};
        rows[5] = '{0, 1, 9, 3, 1};
        rows[6] = '{0, 0, 0, 0, 1};
        rows[7] = '{1, 0, 0, 0, 0};
        rows[8] = '{0, 1, 15, 1, 1};
        model_clear();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_out_accum", out_accum, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_done", drain_done, 0);
        chk("rst_err", err_index, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        drain(0, 0, 0, -1, 0);

        // Accumulate back-to-back, then drain with a 4-cycle stall at id 3
        for (int i = 0; i < 4; i++) apply_row(i);
        idle();
        drain(0, 0, 0, 3, 4);
        chk("acc_id2", obs_acc[2], rep_acc(15));
        chk("cnt_id2", obs_cnt[2], 3);
        chk("acc_id7", obs_acc[7], rep_acc(100));
        chk("cnt_id7", obs_cnt[7], 1);
        chk("acc_id0", obs_acc[0], 0);

        // Bad index sets sticky err; clear drops it
        for (int i = 4; i < 9; i++) apply_row(i);
        rows[0] = '{1, 0, 0, 0, 0};
        apply_row(0);
        idle();

        // Clear beats a same-cycle point; drain_start with a point reports it
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b1; in_index = IW'(1); in_point = rep_pt(9);
        model_clear();
        idle();
        drain(1, 0, 4, -1, 0);
        chk("prio_cnt_id1", obs_cnt[1], 0);
        chk("prio_acc_id0", obs_acc[0], rep_acc(4));
        chk("prio_cnt_id0", obs_cnt[0], 1);

        // Random traffic vs. model
        @(negedge clk);
        clear = 1'b1; model_clear();
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            clear    = ($urandom_range(0, 59) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            idx      = $urandom_range(0, 9);
            for (int l = 0; l < D; l++) pt[l*CW +: CW] = CW'($urandom_range(0, (1 << CW) - 1));
            in_index = IW'(idx);
            in_point = pt;
            if (clear) model_clear();
            else if (in_valid) model_accept(idx, pt);
            @(posedge clk);
            #1;
            chk("rnd_err", err_index, m_err);
        end
        idle();
        drain(0, 0, 0, $urandom_range(0, K - 1), $urandom_range(0, 3));

        // Counter overflow: 1025 points into id 4
        @(negedge clk);
        clear = 1'b1; model_clear();
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b1; in_index = IW'(4); in_point = rep_pt(1);
        for (int c = 0; c < 1025; c++) begin
            model_accept(4, rep_pt(1));
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("ovf_flag", overflow, SAT ? 1 : 0);
        chk("ovf_model", overflow, m_ovf);
        drain(0, 0, 0, -1, 0);
        chk("ovf_cnt", obs_cnt[4], SAT ? 1023 : 1);
        chk("ovf_acc", obs_acc[4], rep_acc(1025));

        // Reset mid-drain
        @(negedge clk);
        drain_start = 1'b1;
        @(negedge clk);
        drain_start = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_abort_valid", out_valid, 0);
        chk("rst_abort_ready", in_ready, 1);
        chk("rst_abort_ovf", overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        drain(0, 0, 0, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
